// File: rtl/dds_ram_pkg.sv
// Shared constants and state encoding for the DDS table RAM path.
// Used by both the write-side and read-side RAM controllers.
package dds_ram_pkg;

    localparam int DDS_START_DELAY = 260;
    localparam int DDS_ADDR_W      = 8;
    localparam int DDS_WORDS       = 256;

    typedef enum logic [2:0] {
        IDLE,
        GUARD,
        WAIT_HI,
        WAIT_LO,
        FINISH
    } ram_wr_state_t;

endpackage

// File: rtl/start_front_det.sv
// Start-line synchronizer with a 001 rising-edge detect.
// Shared by the DDS RAM read and write controllers.
module start_front_det (
    input  logic clk,
    input  logic rst_n,
    input  logic i_start,
    output logic o_front
);

    logic [2:0] r_front_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_front_start <= 3'b000;
        end else begin
            r_front_start <= {r_front_start[1:0], i_start};
        end
    end

    assign o_front = (r_front_start == 3'b001);

endmodule

// File: rtl/ram_write_control_dds.sv
// Pairs an SPI byte stream high-first into 16-bit words and writes
// them to consecutive DDS table RAM addresses after a start guard.
module ram_write_control_dds
    import dds_ram_pkg::*;
#(
    parameter int ADDR_W      = DDS_ADDR_W,
    parameter int WORDS       = DDS_WORDS,
    parameter int START_DELAY = DDS_START_DELAY
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        data8,
    input  logic              data8_valid,
    output logic [ADDR_W-1:0] addr_wr,
    output logic [15:0]       data_wr,
    output logic              we,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int DLY_W = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WORDS);
    localparam logic [DLY_W-1:0] LAST_DLY = DLY_W'(START_DELAY - 1);

    ram_wr_state_t     r_state;
    logic [DLY_W-1:0]  r_dly;
    logic [CNT_W-1:0]  r_wcnt;
    logic [7:0]        r_hi;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_data;
    logic              r_we;
    logic              r_busy;
    logic              r_done;
    logic              w_front;
    logic [CNT_W-1:0]  w_wcnt_nxt;

    start_front_det u_front (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (start),
        .o_front (w_front)
    );

    assign w_wcnt_nxt = r_wcnt + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_dly   <= '0;
            r_wcnt  <= '0;
            r_hi    <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_we    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_we   <= 1'b0;
            r_done <= 1'b0;
            // address moves after the write so it is stable during we
            if (r_we) begin
                r_addr <= r_addr + ADDR_W'(1);
            end
            if (w_front) begin
                r_state <= GUARD;
                r_dly   <= '0;
                r_wcnt  <= '0;
                r_addr  <= '0;
                r_busy  <= 1'b1;
            end else begin
                unique case (r_state)
                    IDLE: begin
                    end
                    GUARD: begin
                        if (r_dly == LAST_DLY) begin
                            r_state <= WAIT_HI;
                        end else begin
                            r_dly <= r_dly + DLY_W'(1);
                        end
                    end
                    WAIT_HI: begin
                        if (data8_valid) begin
                            r_hi    <= data8;
                            r_state <= WAIT_LO;
                        end
                    end
                    WAIT_LO: begin
                        if (data8_valid) begin
                            r_data  <= {r_hi, data8};
                            r_we    <= 1'b1;
                            r_wcnt  <= w_wcnt_nxt;
                            r_state <= (w_wcnt_nxt == LAST_CNT) ? FINISH
                                                                : WAIT_HI;
                        end
                    end
                    FINISH: begin
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign addr_wr = r_addr;
    assign data_wr = r_data;
    assign we      = r_we;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_ram_write_control_dds.sv
// Randomized bench for ram_write_control_dds against a frame-level model.
// Two instances: WORDS=4 and the default 256-word configuration.
module tb_ram_write_control_dds;

    localparam int AW  = 8;
    localparam int DLY = 260;
    localparam int INF = 32'h7fffffff;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          valid = 1'b0;
    logic [7:0]    data8 = 8'h00;
    logic [AW-1:0] a0, a1;
    logic [15:0]   d0, d1;
    logic          we0, we1, b0, b1, dn0, dn1;

    ram_write_control_dds #(.ADDR_W(AW), .WORDS(4), .START_DELAY(DLY)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .data8(data8),
        .data8_valid(valid), .addr_wr(a0), .data_wr(d0), .we(we0),
        .busy(b0), .done(dn0)
    );

    ram_write_control_dds dut (
        .clk(clk), .rst_n(rst_n), .start(start), .data8(data8),
        .data8_valid(valid), .addr_wr(a1), .data_wr(d1), .we(we1),
        .busy(b1), .done(dn1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int c;
        int a;
        int d;
    } wr_t;

    wr_t q0[$], q1[$], log0[$], log1[$];
    int checks = 0;
    int errors = 0;

    bit         m_act[2];
    bit         m_hashi[2];
    logic [7:0] m_hi[2];
    int         m_idx[2];
    int         m_done[2] = '{-1, -1};
    int         m_bf[2]   = '{INF, INF};
    int         m_bt[2]   = '{INF, INF};
    int         m_gend    = INF;
    int         dcnt[2]   = '{0, 0};

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
        end
    endtask

    // Frame-level reference: a start opens a frame, strobes after the
    // guard window pair into words, the WORDS-th word closes the frame.
    task automatic model_start(input int s);
        for (int i = 0; i < 2; i++) begin
            if (!m_act[i]) m_bf[i] = s + 2;
            m_bt[i]    = INF;
            m_act[i]   = 1'b1;
            m_hashi[i] = 1'b0;
            m_idx[i]   = 0;
        end
        m_gend = s + 2 + DLY;
    endtask

    task automatic model_strobe(input int e, input logic [7:0] b);
        wr_t w;
        int  nw;
        for (int i = 0; i < 2; i++) begin
            nw = (i == 0) ? 4 : 256;
            if (m_act[i] && e >= m_gend) begin
                if (!m_hashi[i]) begin
                    m_hi[i]    = b;
                    m_hashi[i] = 1'b1;
                end else begin
                    m_hashi[i] = 1'b0;
                    w.c = e + 1;
                    w.a = m_idx[i] % (1 << AW);
                    w.d = {16'h0, m_hi[i], b};
                    if (i == 0) q0.push_back(w);
                    else        q1.push_back(w);
                    m_idx[i]++;
                    if (m_idx[i] == nw) begin
                        m_done[i] = e + 2;
                        m_bt[i]   = e + 2;
                        m_act[i]  = 1'b0;
                    end
                end
            end
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_act[i]   = 1'b0;
            m_hashi[i] = 1'b0;
            m_done[i]  = -1;
            m_bf[i]    = INF;
            m_bt[i]    = INF;
        end
        m_gend = INF;
    endtask

    always @(negedge clk) begin
        wr_t e;
        bit  ew;
        while (q0.size() > 0 && q0[0].c < cyc) begin
            chk("we0_missing", 0, 1);
            void'(q0.pop_front());
        end
        ew = (q0.size() > 0 && q0[0].c == cyc);
        chk("we0", we0, ew);
        if (ew) begin
            e = q0.pop_front();
            chk("addr0", a0, e.a);
            chk("data0", d0, e.d);
        end
        if (we0) begin
            e.c = cyc; e.a = int'(a0); e.d = int'(d0);
            log0.push_back(e);
        end
        chk("done0", dn0, cyc == m_done[0]);
        chk("busy0", b0, cyc >= m_bf[0] && cyc < m_bt[0]);
        if (dn0) dcnt[0]++;
    end

    always @(negedge clk) begin
        wr_t e;
        bit  ew;
        while (q1.size() > 0 && q1[0].c < cyc) begin
            chk("we1_missing", 0, 1);
            void'(q1.pop_front());
        end
        ew = (q1.size() > 0 && q1[0].c == cyc);
        chk("we1", we1, ew);
        if (ew) begin
            e = q1.pop_front();
            chk("addr1", a1, e.a);
            chk("data1", d1, e.d);
        end
        if (we1) begin
            e.c = cyc; e.a = int'(a1); e.d = int'(d1);
            log1.push_back(e);
        end
        chk("done1", dn1, cyc == m_done[1]);
        chk("busy1", b1, cyc >= m_bf[1] && cyc < m_bt[1]);
        if (dn1) dcnt[1]++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        model_start(cyc);
        tick();
        start = 1'b0;
        idle(2);
    endtask

    task automatic wait_guard();
        while (cyc < m_gend) tick();
    endtask

    task automatic strobe(input logic [7:0] b);
        data8 = b;
        valid = 1'b1;
        model_strobe(cyc, b);
        tick();
        valid = 1'b0;
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_we0"}, we0, 0);
        chk({nm, "_we1"}, we1, 0);
        chk({nm, "_a0"}, a0, 0);
        chk({nm, "_a1"}, a1, 0);
        chk({nm, "_d0"}, d0, 0);
        chk({nm, "_d1"}, d1, 0);
        chk({nm, "_b0"}, b0, 0);
        chk({nm, "_b1"}, b1, 0);
        chk({nm, "_dn0"}, dn0, 0);
        chk({nm, "_dn1"}, dn1, 0);
    endtask

    int nomd[4] = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0};
    int d_before, n_aa;
    logic [7:0] bytes_nom[8] = '{8'h12, 8'h34, 8'h56, 8'h78,
                                 8'h9A, 8'hBC, 8'hDE, 8'hF0};

    initial begin
        idle(3);
        chk_quiet("reset");
        rst_n = 1'b1;
        idle(3);

        // nominal 4-word frame
        log0.delete();
        d_before = dcnt[0];
        do_start();
        wait_guard();
        for (int k = 0; k < 8; k++) strobe(bytes_nom[k]);
        idle(6);
        chk("nom_count", log0.size(), 4);
        if (log0.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("nom_addr", log0[k].a, k);
                chk("nom_data", log0[k].d, nomd[k]);
            end
        end
        chk("nom_done", dcnt[0] - d_before, 1);
        chk("nom_busy", b0, 0);

        // bytes during guard are dropped
        log0.delete();
        do_start();
        idle(50);
        for (int k = 0; k < 5; k++) strobe(8'hAA);
        wait_guard();
        strobe(8'h11);
        strobe(8'h22);
        for (int k = 0; k < 6; k++) strobe(8'h33 + 8'(k));
        idle(6);
        chk("guard_first", log0.size() > 0 ? log0[0].d : 0, 16'h1122);
        n_aa = 0;
        foreach (log0[k])
            if (log0[k].d[15:8] == 8'hAA || log0[k].d[7:0] == 8'hAA) n_aa++;
        chk("guard_noaa", n_aa, 0);

        // restart mid-frame
        log0.delete();
        d_before = dcnt[0];
        do_start();
        wait_guard();
        for (int k = 0; k < 7; k++) strobe(8'($urandom));
        idle(5);
        do_start();
        wait_guard();
        strobe(8'h01);
        strobe(8'h02);
        for (int k = 0; k < 6; k++) strobe(8'($urandom));
        idle(6);
        chk("rst_count", log0.size(), 7);
        chk("rst_first", log0.size() > 3 ? log0[3].d : 0, 16'h0102);
        chk("rst_addr", log0.size() > 3 ? log0[3].a : -1, 0);
        chk("rst_done", dcnt[0] - d_before, 1);

        // sparse strobes, 7 cycles apart
        do_start();
        wait_guard();
        for (int k = 0; k < 8; k++) begin
            strobe(8'($urandom));
            idle(6);
        end
        idle(4);

        // full 256-word frame with address wrap
        log1.delete();
        d_before = dcnt[1];
        do_start();
        wait_guard();
        for (int k = 0; k < 512; k++) strobe(8'(k));
        idle(6);
        chk("wrap_count", log1.size(), 256);
        chk("wrap_first", log1.size() > 0 ? log1[0].d : 0, 16'h0001);
        chk("wrap_last_a", log1.size() == 256 ? log1[255].a : -1, 255);
        chk("wrap_last_d", log1.size() == 256 ? log1[255].d : 0, 16'hFEFF);
        chk("wrap_addr0", a1, 0);
        chk("wrap_done", dcnt[1] - d_before, 1);

        // async reset in WAIT_LO
        do_start();
        wait_guard();
        strobe(8'h5A);
        idle(2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_quiet("areset");
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) strobe(8'($urandom));
        idle(4);

        // randomized frames
        for (int r = 0; r < 4; r++) begin
            do_start();
            wait_guard();
            for (int k = 0; k < int'($urandom_range(4, 12)); k++) begin
                strobe(8'($urandom));
                idle($urandom_range(0, 3));
            end
            idle(5);
        end

        idle(6);
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
